// File: rtl/br_ckpt_stack_pkg.sv
// Shared sizing, checkpoint entry type and CDB snoop helper for the branch checkpoint stack.
package br_ckpt_stack_pkg;

  localparam int unsigned BR_NUM    = 5;
  localparam int unsigned MT_NUM    = 32;
  localparam int unsigned PRF_IDX_W = 6;
  localparam int unsigned FL_PTR_W  = 5;
  localparam int unsigned MT_ENT_W  = PRF_IDX_W + 1;
  localparam int unsigned MT_W      = MT_NUM * MT_ENT_W;

  typedef logic [BR_NUM-1:0]    br_mask_t;
  typedef logic [MT_W-1:0]      mt_snap_t;
  typedef logic [FL_PTR_W-1:0]  fl_ptr_t;
  typedef logic [PRF_IDX_W-1:0] prf_tag_t;

  typedef struct packed {
    logic     vld;
    br_mask_t dep_mask;
    mt_snap_t mt;
    fl_ptr_t  fl_head;
  } ckpt_entry_t;

  typedef enum logic [1:0] {
    RSV_NONE    = 2'd0,
    RSV_CORRECT = 2'd1,
    RSV_WRONG   = 2'd2
  } rsv_kind_e;

  // Each map-table entry is {ready, tag}; a matching CDB tag sets ready.
  function automatic mt_snap_t cdb_snoop(input mt_snap_t mt, input logic vld, input prf_tag_t tag);
    mt_snap_t r;
    r = mt;
    if (vld) begin
      for (int unsigned i = 0; i < MT_NUM; i++) begin
        if (mt[i*MT_ENT_W +: PRF_IDX_W] == tag) begin
          r[i*MT_ENT_W + PRF_IDX_W] = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/br_ckpt_entry.sv
// One branch checkpoint: valid bit, older-branch dependency mask, map-table and free-list snapshot.
module br_ckpt_entry
  import br_ckpt_stack_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_i,
  input  logic        free_i,
  input  br_mask_t    dep_i,
  input  br_mask_t    clr_i,
  input  mt_snap_t    mt_i,
  input  fl_ptr_t     fl_head_i,
  input  logic        cdb_vld_i,
  input  prf_tag_t    cdb_tag_i,
  output ckpt_entry_t ent_o
);

  ckpt_entry_t ent_q, ent_d;

  // Allocation overrides a same-cycle free so a freed slot can be reused immediately.
  always_comb begin
    ent_d          = ent_q;
    ent_d.dep_mask = ent_q.dep_mask & ~clr_i;
    if (ent_q.vld) begin
      ent_d.mt = cdb_snoop(ent_q.mt, cdb_vld_i, cdb_tag_i);
    end
    if (free_i) begin
      ent_d.vld = 1'b0;
    end
    if (alloc_i) begin
      ent_d.vld      = 1'b1;
      ent_d.dep_mask = dep_i;
      ent_d.mt       = cdb_snoop(mt_i, cdb_vld_i, cdb_tag_i);
      ent_d.fl_head  = fl_head_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign ent_o = ent_q;

endmodule

// File: rtl/br_ckpt_stack.sv
// Branch checkpoint stack top: priority allocator, resolve/squash logic and recovery mux.
// Optional BR_CKPT_FULL_FWD_EN: while full, a correct resolve's slot is re-granted the same cycle.
module br_ckpt_stack
  import br_ckpt_stack_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 alloc_i,
  input  logic [MT_NUM*(PRF_IDX_W+1)-1:0]      bak_mt_i,
  input  logic [FL_PTR_W-1:0]                  bak_fl_head_i,
  input  logic                                 rsv_vld_i,
  input  logic [BR_NUM-1:0]                    rsv_bit_i,
  input  logic                                 rsv_wrong_i,
  input  logic                                 cdb_vld_i,
  input  logic [PRF_IDX_W-1:0]                 cdb_tag_i,
  output logic [BR_NUM-1:0]                    alloc_bit_o,
  output logic [BR_NUM-1:0]                    br_mask_o,
  output logic                                 full_o,
  output logic [BR_NUM-1:0]                    clr_bit_o,
  output logic                                 rc_vld_o,
  output logic [BR_NUM-1:0]                    squash_mask_o,
  output logic [MT_NUM*(PRF_IDX_W+1)-1:0]      rc_mt_o,
  output logic [FL_PTR_W-1:0]                  rc_fl_head_o
);

  ckpt_entry_t ent [BR_NUM];
  br_mask_t    vld;
  br_mask_t    free_pick;
  br_mask_t    alloc_bit;
  br_mask_t    clr_bit;
  br_mask_t    squash;
  logic        alloc_fire;
  logic        found;
  rsv_kind_e   rsv_kind;
  mt_snap_t    sel_mt;
  fl_ptr_t     sel_fl;

  always_comb begin
    vld = '0;
    for (int unsigned i = 0; i < BR_NUM; i++) begin
      vld[i] = ent[i].vld;
    end
  end

  assign br_mask_o = vld;
  assign full_o    = &vld;

  always_comb begin
    rsv_kind = RSV_NONE;
    if (!rst && rsv_vld_i && |(rsv_bit_i & vld)) begin
      rsv_kind = rsv_wrong_i ? RSV_WRONG : RSV_CORRECT;
    end
  end

  assign clr_bit = (rsv_kind == RSV_CORRECT) ? rsv_bit_i : '0;

  always_comb begin
    free_pick = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < BR_NUM; i++) begin
      if (!vld[i] && !found) begin
        free_pick[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    alloc_bit = '0;
    if (!rst && !(rsv_vld_i && rsv_wrong_i)) begin
      if (!full_o) begin
        alloc_bit = free_pick;
      end else begin
`ifdef BR_CKPT_FULL_FWD_EN
        alloc_bit = clr_bit;
`else
        alloc_bit = '0;
`endif
      end
    end
  end

  assign alloc_fire = alloc_i && (|alloc_bit);

  // Younger branches carry the mispredicted bit in their dependency mask.
  always_comb begin
    squash = '0;
    if (rsv_kind == RSV_WRONG) begin
      squash = rsv_bit_i;
      for (int unsigned i = 0; i < BR_NUM; i++) begin
        if (vld[i] && |(ent[i].dep_mask & rsv_bit_i)) begin
          squash[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_mt = '0;
    sel_fl = '0;
    for (int unsigned i = 0; i < BR_NUM; i++) begin
      if (rsv_bit_i[i]) begin
        sel_mt = sel_mt | ent[i].mt;
        sel_fl = sel_fl | ent[i].fl_head;
      end
    end
  end

  assign alloc_bit_o   = alloc_bit;
  assign clr_bit_o     = clr_bit;
  assign rc_vld_o      = (rsv_kind == RSV_WRONG);
  assign squash_mask_o = squash;
  assign rc_mt_o       = (rsv_kind == RSV_WRONG) ? cdb_snoop(sel_mt, cdb_vld_i, cdb_tag_i) : '0;
  assign rc_fl_head_o  = (rsv_kind == RSV_WRONG) ? sel_fl : '0;

  for (genvar g = 0; g < BR_NUM; g++) begin : g_ent
    br_ckpt_entry u_ent (
      .clk       (clk),
      .rst       (rst),
      .alloc_i   (alloc_fire && alloc_bit[g]),
      .free_i    (clr_bit[g] || squash[g]),
      .dep_i     (vld & ~clr_bit),
      .clr_i     (clr_bit),
      .mt_i      (bak_mt_i),
      .fl_head_i (bak_fl_head_i),
      .cdb_vld_i (cdb_vld_i),
      .cdb_tag_i (cdb_tag_i),
      .ent_o     (ent[g])
    );
  end

endmodule

// File: tb/tb_br_ckpt_stack.sv
// Directed scoreboard bench for br_ckpt_stack; follows BR_CKPT_FULL_FWD_EN for the full-forward case.
module tb_br_ckpt_stack;
  import br_ckpt_stack_pkg::*;

  logic           clk;
  logic           rst;
  logic           alloc_i;
  mt_snap_t       bak_mt_i;
  fl_ptr_t        bak_fl_head_i;
  logic           rsv_vld_i;
  br_mask_t       rsv_bit_i;
  logic           rsv_wrong_i;
  logic           cdb_vld_i;
  prf_tag_t       cdb_tag_i;
  br_mask_t       alloc_bit_o;
  br_mask_t       br_mask_o;
  logic           full_o;
  br_mask_t       clr_bit_o;
  logic           rc_vld_o;
  br_mask_t       squash_mask_o;
  mt_snap_t       rc_mt_o;
  fl_ptr_t        rc_fl_head_o;

  br_ckpt_stack dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_i       (alloc_i),
    .bak_mt_i      (bak_mt_i),
    .bak_fl_head_i (bak_fl_head_i),
    .rsv_vld_i     (rsv_vld_i),
    .rsv_bit_i     (rsv_bit_i),
    .rsv_wrong_i   (rsv_wrong_i),
    .cdb_vld_i     (cdb_vld_i),
    .cdb_tag_i     (cdb_tag_i),
    .alloc_bit_o   (alloc_bit_o),
    .br_mask_o     (br_mask_o),
    .full_o        (full_o),
    .clr_bit_o     (clr_bit_o),
    .rc_vld_o      (rc_vld_o),
    .squash_mask_o (squash_mask_o),
    .rc_mt_o       (rc_mt_o),
    .rc_fl_head_o  (rc_fl_head_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [255:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic ex(input string tag, input logic [255:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic ck(input string tag, input logic [255:0] obs);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %0h with no expected value queued", tag, obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s (%s): observed %0h expected %0h", tag, e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mt_snap_t mk_mt(input int unsigned tag, input logic rdy);
    mt_snap_t m;
    logic [6:0] ent;
    m   = '0;
    ent = {rdy, tag[5:0]};
    m[6:0] = ent;
    return m;
  endfunction

  task automatic do_alloc(input int unsigned head, input int unsigned tag, input logic [4:0] grant);
    alloc_i       = 1'b1;
    bak_fl_head_i = head[4:0];
    bak_mt_i      = mk_mt(tag, 1'b0);
    #1;
    ex("alloc_bit", grant);
    ck("alloc_bit", alloc_bit_o);
    tick();
    alloc_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && rsv_vld_i) begin
      assert ($onehot(rsv_bit_i)) else $error("FAIL rsv_onehot: observed %b expected one-hot", rsv_bit_i);
    end
  end

  initial begin
    rst = 1'b1; alloc_i = 1'b1; bak_mt_i = '0; bak_fl_head_i = '0;
    rsv_vld_i = 1'b1; rsv_bit_i = 5'b00001; rsv_wrong_i = 1'b1;
    cdb_vld_i = 1'b1; cdb_tag_i = '0;
    tick();
    tick();
    ex("rst_mask", 0);    ck("rst_mask", br_mask_o);
    ex("rst_full", 0);    ck("rst_full", full_o);
    ex("rst_alloc", 0);   ck("rst_alloc", alloc_bit_o);
    ex("rst_rcvld", 0);   ck("rst_rcvld", rc_vld_o);
    ex("rst_squash", 0);  ck("rst_squash", squash_mask_o);
    rsv_wrong_i = 1'b0;
    #1;
    ex("rst_clr", 0);     ck("rst_clr", clr_bit_o);
    ex("rst_alloc2", 0);  ck("rst_alloc2", alloc_bit_o);
    rst = 1'b0; alloc_i = 1'b0; rsv_vld_i = 1'b0; rsv_bit_i = '0; cdb_vld_i = 1'b0;
    #1;

    // Fill all five checkpoints, then try a sixth.
    for (int k = 0; k < 5; k++) begin
      do_alloc(10 + k, 1 + k, 5'(1 << k));
      ex("fill_mask", (1 << (k + 1)) - 1);
      ck("fill_mask", br_mask_o);
    end
    ex("fill_full", 1); ck("fill_full", full_o);
    alloc_i = 1'b1;
    #1;
    ex("sixth_alloc", 0); ck("sixth_alloc", alloc_bit_o);
    tick();
    alloc_i = 1'b0;
    ex("sixth_mask", 5'b11111); ck("sixth_mask", br_mask_o);

    // Correct resolves from full, then one on an already freed bit.
    rsv_vld_i = 1'b1; rsv_wrong_i = 1'b0; rsv_bit_i = 5'b00100;
    #1;
    ex("clr_a", 5'b00100); ck("clr_a", clr_bit_o);
    ex("clr_a_rc", 0);     ck("clr_a_rc", rc_vld_o);
    tick();
    ex("clr_a_mask", 5'b11011); ck("clr_a_mask", br_mask_o);
    ex("clr_a_full", 0);        ck("clr_a_full", full_o);
    rsv_bit_i = 5'b01000;
    #1;
    ex("clr_b", 5'b01000); ck("clr_b", clr_bit_o);
    tick();
    ex("clr_b_mask", 5'b10011); ck("clr_b_mask", br_mask_o);
    rsv_bit_i = 5'b00100;
    #1;
    ex("clr_inval", 0); ck("clr_inval", clr_bit_o);
    tick();
    ex("clr_inval_mask", 5'b10011); ck("clr_inval_mask", br_mask_o);
    rsv_vld_i = 1'b0; rsv_bit_i = '0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex("rst2_mask", 0); ck("rst2_mask", br_mask_o);

    // Nested branches, mispredict the middle one.
    do_alloc(20, 3, 5'b00001);
    do_alloc(21, 5, 5'b00010);
    do_alloc(22, 7, 5'b00100);
    ex("nest_mask", 5'b00111); ck("nest_mask", br_mask_o);
    alloc_i = 1'b1; rsv_vld_i = 1'b1; rsv_wrong_i = 1'b1; rsv_bit_i = 5'b00010;
    #1;
    ex("wr_rcvld", 1);         ck("wr_rcvld", rc_vld_o);
    ex("wr_squash", 5'b00110); ck("wr_squash", squash_mask_o);
    ex("wr_flhead", 21);       ck("wr_flhead", rc_fl_head_o);
    ex("wr_mt", 7'h05);        ck("wr_mt", rc_mt_o[6:0]);
    ex("wr_alloc", 0);         ck("wr_alloc", alloc_bit_o);
    ex("wr_clr", 0);           ck("wr_clr", clr_bit_o);
    cdb_vld_i = 1'b1; cdb_tag_i = 6'd5;
    #1;
    ex("wr_mt_cdb", 7'h45);    ck("wr_mt_cdb", rc_mt_o[6:0]);
    tick();
    alloc_i = 1'b0; rsv_vld_i = 1'b0; rsv_bit_i = '0; cdb_vld_i = 1'b0;
    ex("wr_mask", 5'b00001);   ck("wr_mask", br_mask_o);

    // Registered CDB snoop into a stored snapshot.
    cdb_vld_i = 1'b1; cdb_tag_i = 6'd3;
    tick();
    cdb_vld_i = 1'b0;
    rsv_vld_i = 1'b1; rsv_wrong_i = 1'b1; rsv_bit_i = 5'b00001;
    #1;
    ex("snoop_mt", 7'h43);     ck("snoop_mt", rc_mt_o[6:0]);
    ex("snoop_fl", 20);        ck("snoop_fl", rc_fl_head_o);
    ex("snoop_squash", 5'b00001); ck("snoop_squash", squash_mask_o);
    tick();
    rsv_vld_i = 1'b0; rsv_bit_i = '0;
    ex("snoop_mask", 0);       ck("snoop_mask", br_mask_o);

    // Full plus same-cycle alloc and correct resolve.
    for (int k = 0; k < 5; k++) begin
      do_alloc(k, 10 + k, 5'(1 << k));
    end
    ex("full2_mask", 5'b11111); ck("full2_mask", br_mask_o);
    alloc_i = 1'b1; rsv_vld_i = 1'b1; rsv_wrong_i = 1'b0; rsv_bit_i = 5'b00100;
    #1;
    ex("fwd_clr", 5'b00100); ck("fwd_clr", clr_bit_o);
`ifdef BR_CKPT_FULL_FWD_EN
    ex("fwd_alloc", 5'b00100); ck("fwd_alloc", alloc_bit_o);
    tick();
    ex("fwd_mask", 5'b11111);  ck("fwd_mask", br_mask_o);
    ex("fwd_full", 1);         ck("fwd_full", full_o);
`else
    ex("fwd_alloc", 0);        ck("fwd_alloc", alloc_bit_o);
    tick();
    ex("fwd_mask", 5'b11011);  ck("fwd_mask", br_mask_o);
    ex("fwd_full", 0);         ck("fwd_full", full_o);
`endif
    alloc_i = 1'b0; rsv_vld_i = 1'b0; rsv_bit_i = '0;

    // Reset with branches outstanding.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_alloc(1, 1, 5'b00001);
    do_alloc(2, 2, 5'b00010);
    do_alloc(3, 3, 5'b00100);
    ex("pre_rst_mask", 5'b00111); ck("pre_rst_mask", br_mask_o);
    rst = 1'b1; alloc_i = 1'b1; rsv_vld_i = 1'b1; rsv_wrong_i = 1'b1; rsv_bit_i = 5'b00010;
    #1;
    ex("mid_rst_rcvld", 0);  ck("mid_rst_rcvld", rc_vld_o);
    ex("mid_rst_squash", 0); ck("mid_rst_squash", squash_mask_o);
    ex("mid_rst_fl", 0);     ck("mid_rst_fl", rc_fl_head_o);
    ex("mid_rst_alloc", 0);  ck("mid_rst_alloc", alloc_bit_o);
    tick();
    ex("mid_rst_mask", 0);   ck("mid_rst_mask", br_mask_o);
    ex("mid_rst_full", 0);   ck("mid_rst_full", full_o);
    rst = 1'b0; rsv_vld_i = 1'b0; rsv_bit_i = '0; rsv_wrong_i = 1'b0;
    #1;
    ex("post_rst_alloc", 5'b00001); ck("post_rst_alloc", alloc_bit_o);
    tick();
    alloc_i = 1'b0;
    ex("post_rst_mask", 5'b00001);  ck("post_rst_mask", br_mask_o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
